ifft8_seq: RTL and testbench

IFFT8_SEQ -- requirements
Module: ifft8_seq

---
 rtl/ifft8_seq.sv | 158 +++++++++++++++
 tb/tb_ifft8_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft8_seq.sv
// 8-point inverse FFT, sequential: load 8 samples, run 12 radix-2 DIF butterflies
// through one shared datapath, then stream out the time-domain samples divided by 8.
module ifft8_seq #(
    parameter logic signed [15:0] COS45 = 16'sd23170
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_real,
    input  logic signed [31:0] in_imag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_real,
    output logic signed [31:0] out_imag,
    output logic [2:0]         out_index,
    output logic               busy
);

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_e;

    state_e             state_q, state_d;
    logic [2:0]         load_cnt_q, load_cnt_d;
    logic [3:0]         step_q, step_d;
    logic [2:0]         m_q, m_d;
    logic signed [31:0] mem_re [8];
    logic signed [31:0] mem_im [8];

    logic               in_acc, out_acc;
    logic [1:0]         j;
    logic [2:0]         a_idx, b_idx, rd_idx;
    logic [1:0]         tw;
    logic signed [31:0] sr, si, dr, di, tr, ti, pxt, pyt;
    logic signed [47:0] px, py;

    assign in_acc = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;
    assign rd_idx = {m_q[0], m_q[1], m_q[2]};

    // Butterfly schedule: step[3:2] selects the stage, step[1:0] the pair within it.
    assign j = step_q[1:0];
    always_comb begin
        a_idx = {1'b0, j};
        b_idx = {1'b1, j};
        tw    = j;
        case (step_q[3:2])
            2'd1: begin
                a_idx = {j[1], 1'b0, j[0]};
                b_idx = {j[1], 1'b1, j[0]};
                tw    = {j[0], 1'b0};
            end
            2'd2: begin
                a_idx = {j, 1'b0};
                b_idx = {j, 1'b1};
                tw    = 2'd0;
            end
            default: ;
        endcase
    end

    // Shared butterfly: a' = a+b, b' = (a-b) * conj twiddle
    always_comb begin
        sr = mem_re[a_idx] + mem_re[b_idx];
        si = mem_im[a_idx] + mem_im[b_idx];
        dr = mem_re[a_idx] - mem_re[b_idx];
        di = mem_im[a_idx] - mem_im[b_idx];
    end

    assign px  = 48'(dr) * 48'(COS45);
    assign py  = 48'(di) * 48'(COS45);
    assign pxt = 32'(px >>> 15);
    assign pyt = 32'(py >>> 15);

    always_comb begin
        tr = dr;
        ti = di;
        case (tw)
            2'd1: begin tr = pxt - pyt;  ti = pxt + pyt; end
            2'd2: begin tr = -di;        ti = dr;        end
            2'd3: begin tr = -pxt - pyt; ti = pxt - pyt; end
            default: ;
        endcase
    end

    // Sample memory is deliberately not reset; it is only read after a full reload.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && in_acc) begin
            mem_re[load_cnt_q] <= in_real;
            mem_im[load_cnt_q] <= in_imag;
        end else if (state_q == CALC) begin
            mem_re[a_idx] <= sr;
            mem_im[a_idx] <= si;
            mem_re[b_idx] <= tr;
            mem_im[b_idx] <= ti;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            step_q     <= '0;
            m_q        <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            step_q     <= step_d;
            m_q        <= m_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        step_d     = step_q;
        m_d        = m_q;
        case (state_q)
            LOAD: if (in_acc) begin
                load_cnt_d = load_cnt_q + 3'd1;
                if (load_cnt_q == 3'd7) begin
                    state_d    = CALC;
                    load_cnt_d = '0;
                    step_d     = '0;
                end
            end
            CALC: if (step_q == 4'd11) begin
                state_d = OUT;
                step_d  = '0;
                m_d     = '0;
            end else begin
                step_d = step_q + 4'd1;
            end
            OUT: if (out_acc) begin
                m_d = m_q + 3'd1;
                if (m_q == 3'd7) begin
                    state_d = LOAD;
                    m_d     = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == OUT);
        busy      = (state_q != LOAD);
        out_real  = '0;
        out_imag  = '0;
        out_index = '0;
        if (state_q == OUT) begin
            out_index = m_q;
            out_real  = mem_re[rd_idx] >>> 3;
            out_imag  = mem_im[rd_idx] >>> 3;
        end
    end

endmodule

// File: tb/tb_ifft8_seq.sv
// Scoreboard bench for ifft8_seq: directed frames, streaming timing, backpressure, mid-CALC reset.
module tb_ifft8_seq;

    localparam logic signed [15:0] C45 = 16'sd23170;

    typedef struct {
        logic [2:0]         idx;
        logic signed [31:0] re;
        logic signed [31:0] im;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_real = '0;
    logic signed [31:0] in_imag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [31:0] out_real;
    logic signed [31:0] out_imag;
    logic [2:0]         out_index;
    logic               busy;

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    bit   bp_en = 1'b0;

    ifft8_seq #(.COS45(C45)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_real (out_real),
        .out_imag (out_imag),
        .out_index(out_index),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs,
                     $signed(exp), exp);
        end
    endtask

    task automatic push_exp(input int n, input int re, input int im);
        exp_t e;
        e.idx = 3'(n);
        e.re  = re;
        e.im  = im;
        sb.push_back(e);
    endtask

    // Reference: textbook in-place DIF loop nest, conjugate twiddles, result / 8.
    task automatic push_model(input int xr[8], input int xi[8]);
        int r[8];
        int m[8];
        r = xr;
        m = xi;
        for (int s = 0; s < 3; s++) begin
            for (int st = 0; st < 8; st += (8 >> s)) begin
                for (int q = 0; q < (4 >> s); q++) begin
                    int a, b, k, dr, di, tr, ti, pr, pi;
                    a  = st + q;
                    b  = a + (4 >> s);
                    k  = q << s;
                    dr = r[a] - r[b];
                    di = m[a] - m[b];
                    r[a] = r[a] + r[b];
                    m[a] = m[a] + m[b];
                    pr = int'((longint'(dr) * longint'(C45)) >>> 15);
                    pi = int'((longint'(di) * longint'(C45)) >>> 15);
                    case (k)
                        1:       begin tr = pr - pi;  ti = pr + pi; end
                        2:       begin tr = -di;      ti = dr;      end
                        3:       begin tr = -pr - pi; ti = pr - pi; end
                        default: begin tr = dr;       ti = di;      end
                    endcase
                    r[b] = tr;
                    m[b] = ti;
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            int br;
            br = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            push_exp(n, r[br] >>> 3, m[br] >>> 3);
        end
    endtask

    // Caller is always #1 after a rising edge.
    task automatic send_frame(input int xr[8], input int xi[8]);
        for (int k = 0; k < 8; k++) begin
            int w;
            w = 0;
            in_valid = 1'b1;
            in_real  = xr[k];
            in_imag  = xi[k];
            while (!in_ready && w < 300) begin
                @(posedge clk); #1;
                w++;
            end
            if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || !in_ready) && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pops on handshake, hold check while stalled.
    initial begin
        bit                 stall;
        logic signed [31:0] hr, hi;
        logic [2:0]         hx;
        exp_t               e;
        stall = 1'b0;
        hr = '0; hi = '0; hx = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall && out_valid) begin
                    chk("hold_re", out_real, hr);
                    chk("hold_im", out_imag, hi);
                    chk("hold_idx", 32'(out_index), 32'(hx));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("out_idx", 32'(out_index), 32'(e.idx));
                        chk("out_re", out_real, e.re);
                        chk("out_im", out_imag, e.im);
                    end
                end else if (!out_valid) begin
                    chk("idle_zero", out_real | out_imag | 32'(out_index), 32'd0);
                end
                stall = out_valid && !out_ready;
                hr = out_real;
                hi = out_imag;
                hx = out_index;
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        int xr[8];
        int xi[8];

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_zero", out_real | out_imag | 32'(out_index), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse, streamed with in_valid held high to check timing
        for (int k = 0; k < 8; k++) begin xr[k] = (k == 0) ? 800 : 0; xi[k] = 0; end
        for (int n = 0; n < 8; n++) push_exp(n, 100, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_real = xr[k];
            in_imag = xi[k];
            @(posedge clk); #1;
        end
        chk("in_ready_fall", 32'(in_ready), 32'd0);
        chk("busy_calc", 32'(busy), 32'd1);
        in_real = 32'h5555_5555;
        in_imag = 32'hdead_beef;
        repeat (11) @(posedge clk);
        #1;
        chk("out_valid_edge11", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("out_valid_edge12", 32'(out_valid), 32'd1);
        for (int n = 0; n < 8; n++) begin
            chk("seq_idx", 32'(out_index), 32'(n));
            @(posedge clk); #1;
        end
        chk("in_ready_back", 32'(in_ready), 32'd1);
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        wait_drain();

        // Constant
        for (int k = 0; k < 8; k++) begin xr[k] = 800; xi[k] = 0; end
        for (int n = 0; n < 8; n++) push_exp(n, (n == 0) ? 800 : 0, 0);
        send_frame(xr, xi);
        wait_drain();

        // Single tone at k=1
        for (int k = 0; k < 8; k++) begin xr[k] = (k == 1) ? 8000 : 0; xi[k] = 0; end
        push_exp(0, 1000, 0);     push_exp(1, 707, 707);
        push_exp(2, 0, 1000);     push_exp(3, -707, 707);
        push_exp(4, -1000, 0);    push_exp(5, -707, -707);
        push_exp(6, 0, -1000);    push_exp(7, 707, -707);
        send_frame(xr, xi);
        wait_drain();

        // Random frames under backpressure; the last one uses full-range values to hit wrap
        bp_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                if (f == 2) begin
                    xr[k] = int'($urandom);
                    xi[k] = int'($urandom);
                end else begin
                    xr[k] = int'($urandom_range(0, 2097151)) - 1048576;
                    xi[k] = int'($urandom_range(0, 2097151)) - 1048576;
                end
            end
            push_model(xr, xi);
            send_frame(xr, xi);
            wait_drain();
        end
        bp_en = 1'b0;

        // Reset after butterfly 5 of an unscored frame
        for (int k = 0; k < 8; k++) begin xr[k] = 1000 * k; xi[k] = -77 * k; end
        send_frame(xr, xi);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_rst", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midcalc_out_valid", 32'(out_valid), 32'd0);
        chk("midcalc_in_ready", 32'(in_ready), 32'd1);
        chk("midcalc_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            xr[k] = int'($urandom_range(0, 65535)) - 32768;
            xi[k] = int'($urandom_range(0, 65535)) - 32768;
        end
        push_model(xr, xi);
        send_frame(xr, xi);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
